// File: rtl/keccak_sponge_ctrl.sv
// Sponge controller for Keccak-p[1600]: absorbs a 64-bit lane stream, applies pad10*1 with a
// domain suffix, squeezes rate lanes, and sequences an external permutation core via start/done.
module keccak_sponge_ctrl #(
    parameter int unsigned RATE_LANES = 21,
    parameter logic [7:0]  DOMAIN     = 8'h1F
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_init,
    input  logic [63:0]   i_in_data,
    input  logic          i_in_valid,
    input  logic          i_in_last,
    input  logic [3:0]    i_in_bytes,
    output logic          o_in_ready,
    output logic [63:0]   o_out_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic          o_perm_start,
    output logic [1599:0] o_perm_state,
    input  logic [1599:0] i_perm_result,
    input  logic          i_perm_done
);

    typedef enum logic [2:0] {
        StIdle, StAbsorb, StPermA, StPad, StPermP, StSqueeze, StPermS, StDrain
    } state_e;

    localparam logic [4:0] LastIdx = 5'(RATE_LANES - 1);

    state_e             r_fsm;
    logic [24:0][63:0]  r_s;
    logic [4:0]         r_idx;
    logic [4:0]         r_pad_lane;
    logic [2:0]         r_pad_byte;
    logic               r_pad_pending;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_perm_start;
    logic [63:0]        r_out_data;

    logic [4:0]         w_idx_inc;
    logic [63:0]        w_mask;
    logic [63:0]        w_absorb_lane;
    logic               w_full_last;
    logic               w_in_perm;
    logic               w_done_valid;
    logic [24:0][63:0]  w_pad_s;

    assign w_idx_inc     = r_idx + 5'd1;
    assign w_absorb_lane = r_s[r_idx] ^ (i_in_data & w_mask);
    assign w_full_last   = i_in_bytes >= 4'd8;
    assign w_in_perm     = (r_fsm == StPermA) || (r_fsm == StPermP) ||
                           (r_fsm == StPermS) || (r_fsm == StDrain);
    // done seen while start is still high belongs to the previous run
    assign w_done_valid  = i_perm_done && !r_perm_start;

    always_comb begin
        w_mask = '1;
        if (i_in_last) begin
            for (int k = 0; k < 8; k++) begin
                w_mask[8*k +: 8] = (k < int'(i_in_bytes)) ? 8'hFF : 8'h00;
            end
        end
    end

    // Domain byte and final pad bit may land in the same byte; XOR keeps both.
    always_comb begin
        w_pad_s = r_s;
        w_pad_s[r_pad_lane][{r_pad_byte, 3'b000} +: 8] =
            w_pad_s[r_pad_lane][{r_pad_byte, 3'b000} +: 8] ^ DOMAIN;
        w_pad_s[LastIdx][63:56] = w_pad_s[LastIdx][63:56] ^ 8'h80;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm         <= StIdle;
            r_s           <= '0;
            r_idx         <= '0;
            r_pad_lane    <= '0;
            r_pad_byte    <= '0;
            r_pad_pending <= 1'b0;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_perm_start  <= 1'b0;
            r_out_data    <= '0;
        end else begin
            r_perm_start <= 1'b0;
            if (i_init && !w_in_perm) begin
                r_s           <= '0;
                r_idx         <= '0;
                r_pad_pending <= 1'b0;
                r_fsm         <= StAbsorb;
                r_in_ready    <= 1'b1;
                r_out_valid   <= 1'b0;
                r_out_data    <= '0;
            end else begin
                unique case (r_fsm)
                    StIdle: begin
                    end
                    StAbsorb: begin
                        if (i_in_valid) begin
                            r_s[r_idx] <= w_absorb_lane;
                            if (!i_in_last) begin
                                if (r_idx == LastIdx) begin
                                    r_idx        <= '0;
                                    r_fsm        <= StPermA;
                                    r_perm_start <= 1'b1;
                                    r_in_ready   <= 1'b0;
                                end else begin
                                    r_idx <= w_idx_inc;
                                end
                            end else if (!w_full_last) begin
                                r_pad_lane <= r_idx;
                                r_pad_byte <= i_in_bytes[2:0];
                                r_fsm      <= StPad;
                                r_in_ready <= 1'b0;
                            end else if (r_idx == LastIdx) begin
                                // Block full: permute first, pad opens the next block.
                                r_pad_lane    <= '0;
                                r_pad_byte    <= '0;
                                r_pad_pending <= 1'b1;
                                r_idx         <= '0;
                                r_fsm         <= StPermA;
                                r_perm_start  <= 1'b1;
                                r_in_ready    <= 1'b0;
                            end else begin
                                r_pad_lane <= w_idx_inc;
                                r_pad_byte <= '0;
                                r_fsm      <= StPad;
                                r_in_ready <= 1'b0;
                            end
                        end
                    end
                    StPad: begin
                        r_s           <= w_pad_s;
                        r_idx         <= '0;
                        r_pad_pending <= 1'b0;
                        r_fsm         <= StPermP;
                        r_perm_start  <= 1'b1;
                    end
                    StPermA, StPermP, StPermS: begin
                        if (i_init) begin
                            r_fsm <= StDrain;
                        end else if (w_done_valid) begin
                            r_s <= i_perm_result;
                            if (r_fsm == StPermA) begin
                                if (r_pad_pending) begin
                                    r_fsm <= StPad;
                                end else begin
                                    r_fsm      <= StAbsorb;
                                    r_in_ready <= 1'b1;
                                end
                            end else begin
                                r_fsm       <= StSqueeze;
                                r_out_valid <= 1'b1;
                                r_out_data  <= i_perm_result[63:0];
                            end
                        end
                    end
                    StSqueeze: begin
                        if (i_out_ready) begin
                            if (r_idx == LastIdx) begin
                                r_idx        <= '0;
                                r_fsm        <= StPermS;
                                r_perm_start <= 1'b1;
                                r_out_valid  <= 1'b0;
                            end else begin
                                r_idx      <= w_idx_inc;
                                r_out_data <= r_s[w_idx_inc];
                            end
                        end
                    end
                    StDrain: begin
                        if (w_done_valid) begin
                            r_s           <= '0;
                            r_idx         <= '0;
                            r_pad_pending <= 1'b0;
                            r_fsm         <= StAbsorb;
                            r_in_ready    <= 1'b1;
                            r_out_data    <= '0;
                        end
                    end
                    default: r_fsm <= StIdle;
                endcase
            end
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_perm_start = r_perm_start;
    assign o_perm_state = r_s;

endmodule
